// File: rtl/seq_datapath.sv
// Register-file datapath with a built-in micro-sequencer: one accepted command runs a full
// read Rn / read Rm / execute / write Rd operation and ends with a one-cycle done pulse.
module seq_datapath #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREGS = 8,
  localparam int unsigned RW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [1:0]       cmd_aluop,
  input  logic [1:0]       cmd_shift,
  input  logic [RW-1:0]    cmd_rd,
  input  logic [RW-1:0]    cmd_rn,
  input  logic [RW-1:0]    cmd_rm,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic             done,
  output logic [WIDTH-1:0] datapath_out,
  output logic             Z_out,
  output logic             N_out,
  output logic             V_out,
  input  logic [RW-1:0]    dbg_readnum,
  output logic [WIDTH-1:0] dbg_data
);

  localparam logic [1:0] ModeAlu  = 2'b00;
  localparam logic [1:0] ModeMovi = 2'b01;
  localparam logic [1:0] ModeMovr = 2'b10;
  localparam logic [1:0] ModeCmp  = 2'b11;

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpAnd = 2'b10;
  localparam logic [1:0] OpMvn = 2'b11;

  typedef enum logic [2:0] {StIdle, StLoadA, StLoadB, StExec, StWrite, StWimm} state_e;

  state_e           state_q, state_d;
  logic             done_q, done_d;
  logic             accept;

  logic [1:0]       mode_q, aluop_q, shift_q;
  logic [RW-1:0]    rd_q, rn_q, rm_q;
  logic [WIDTH-1:0] imm_q;

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] a_q, b_q, c_q;
  logic             z_q, n_q, v_q;

  logic [WIDTH-1:0] b_sh, op_a, alu_res;
  logic [1:0]       op;
  logic             alu_v;

  // Sequencer
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    cmd_ready = (state_q == StIdle);
    accept    = cmd_valid && cmd_ready;
    case (state_q)
      StIdle: begin
        if (accept) begin
          unique case (cmd_mode)
            ModeAlu, ModeCmp: state_d = StLoadA;
            ModeMovr:         state_d = StLoadB;
            ModeMovi:         state_d = StWimm;
          endcase
        end
      end
      StLoadA: state_d = StLoadB;
      StLoadB: state_d = StExec;
      StExec: begin
        if (mode_q == ModeCmp) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          state_d = StWrite;
        end
      end
      StWrite, StWimm: begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Shifter and ALU; MOVR forces A to zero and ADD, CMP forces SUB
  always_comb begin
    b_sh    = b_q;
    op_a    = (mode_q == ModeMovr) ? '0 : a_q;
    op      = aluop_q;
    alu_res = '0;
    alu_v   = 1'b0;
    unique case (shift_q)
      2'b00: b_sh = b_q;
      2'b01: b_sh = {b_q[WIDTH-2:0], 1'b0};
      2'b10: b_sh = {1'b0, b_q[WIDTH-1:1]};
      2'b11: b_sh = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
    endcase
    if (mode_q == ModeCmp) begin
      op = OpSub;
    end else if (mode_q == ModeMovr) begin
      op = OpAdd;
    end
    unique case (op)
      OpAdd: begin
        alu_res = op_a + b_sh;
        alu_v   = (op_a[WIDTH-1] == b_sh[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
      end
      OpSub: begin
        alu_res = op_a - b_sh;
        alu_v   = (op_a[WIDTH-1] != b_sh[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
      end
      OpAnd: alu_res = op_a & b_sh;
      OpMvn: alu_res = ~b_sh;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
      mode_q  <= '0;
      aluop_q <= '0;
      shift_q <= '0;
      rd_q    <= '0;
      rn_q    <= '0;
      rm_q    <= '0;
      imm_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (accept) begin
        mode_q  <= cmd_mode;
        aluop_q <= cmd_aluop;
        shift_q <= cmd_shift;
        rd_q    <= cmd_rd;
        rn_q    <= cmd_rn;
        rm_q    <= cmd_rm;
        imm_q   <= cmd_imm;
      end
      case (state_q)
        StLoadA: a_q <= regs_q[rn_q];
        StLoadB: b_q <= regs_q[rm_q];
        StExec: begin
          c_q <= alu_res;
          if (mode_q == ModeAlu || mode_q == ModeCmp) begin
            z_q <= (alu_res == '0);
            n_q <= alu_res[WIDTH-1];
            v_q <= alu_v;
          end
        end
        StWrite: regs_q[rd_q] <= c_q;
        StWimm:  regs_q[rd_q] <= imm_q;
        default: ;
      endcase
    end
  end

  assign done         = done_q;
  assign datapath_out = c_q;
  assign Z_out        = z_q;
  assign N_out        = n_q;
  assign V_out        = v_q;
  assign dbg_data     = regs_q[dbg_readnum];

endmodule

// File: tb/tb_seq_datapath.sv
// Bench for seq_datapath: directed scenarios plus random commands, checked against an
// arithmetic reference model of the register file, C register and flags.
`timescale 1ns/100ps
module tb_seq_datapath;

  localparam logic [1:0] MALU = 2'b00, MMOVI = 2'b01, MMOVR = 2'b10, MCMP = 2'b11;
  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, AND = 2'b10, MVN = 2'b11;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_mode = '0, cmd_aluop = '0, cmd_shift = '0;
  logic [2:0]  cmd_rd = '0, cmd_rn = '0, cmd_rm = '0;
  logic [15:0] cmd_imm = '0;
  logic        done;
  logic [15:0] datapath_out;
  logic        Z_out, N_out, V_out;
  logic [2:0]  dbg_readnum = '0;
  logic [15:0] dbg_data;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] m_r [8];
  logic [15:0] m_c;
  logic        m_z, m_n, m_v;

  seq_datapath #(.WIDTH(16), .NREGS(8)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_aluop(cmd_aluop), .cmd_shift(cmd_shift),
    .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm), .cmd_imm(cmd_imm),
    .done(done), .datapath_out(datapath_out), .Z_out(Z_out), .N_out(N_out), .V_out(V_out),
    .dbg_readnum(dbg_readnum), .dbg_data(dbg_data)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = '0;
    m_c = '0; m_z = 1'b0; m_n = 1'b0; m_v = 1'b0;
  endtask

  // Reference semantics: signed overflow judged on full-range integer arithmetic.
  function automatic int model_exec(input logic [1:0] mode, aluop, shift,
                                    input logic [2:0] rd, rn, rm, input logic [15:0] imm);
    logic [15:0] a, b, res;
    logic signed [15:0] bs;
    logic [1:0] op;
    int sa, sb, full;
    logic v;
    if (mode == MMOVI) begin
      m_r[rd] = imm;
      return 1;
    end
    a = (mode == MMOVR) ? 16'd0 : m_r[rn];
    b = m_r[rm];
    bs = b;
    case (shift)
      2'b01:   b = b << 1;
      2'b10:   b = b >> 1;
      2'b11:   b = bs >>> 1;
      default: b = b;
    endcase
    op = (mode == MCMP) ? SUB : (mode == MMOVR) ? ADD : aluop;
    sa = $signed(a);
    sb = $signed(b);
    v = 1'b0;
    case (op)
      ADD: begin full = sa + sb; res = a + b; v = (full > 32767) || (full < -32768); end
      SUB: begin full = sa - sb; res = a - b; v = (full > 32767) || (full < -32768); end
      AND: res = a & b;
      default: res = ~b;
    endcase
    m_c = res;
    if (mode == MALU || mode == MCMP) begin
      m_z = (res == 16'd0); m_n = res[15]; m_v = v;
    end
    if (mode != MCMP) m_r[rd] = res;
    return (mode == MALU) ? 4 : 3;
  endfunction

  task automatic check_state(input string tag);
    check({tag, "_c"}, {16'd0, datapath_out}, {16'd0, m_c});
    check({tag, "_znv"}, {29'd0, Z_out, N_out, V_out}, {29'd0, m_z, m_n, m_v});
    for (int i = 0; i < 8; i++) begin
      dbg_readnum = i[2:0];
      #1;
      check($sformatf("%s_r%0d", tag, i), {16'd0, dbg_data}, {16'd0, m_r[i]});
    end
  endtask

  task automatic drive(input logic [1:0] mode, aluop, shift, input logic [2:0] rd, rn, rm,
                       input logic [15:0] imm);
    cmd_valid = 1'b1;
    cmd_mode = mode; cmd_aluop = aluop; cmd_shift = shift;
    cmd_rd = rd; cmd_rn = rn; cmd_rm = rm; cmd_imm = imm;
  endtask

  task automatic scramble();
    cmd_valid = 1'b0;
    cmd_mode = 2'($urandom); cmd_aluop = 2'($urandom); cmd_shift = 2'($urandom);
    cmd_rd = 3'($urandom); cmd_rn = 3'($urandom); cmd_rm = 3'($urandom);
    cmd_imm = 16'($urandom);
  endtask

  // Waits up to 8 edges for done; returns edges seen (8 with no done means timeout).
  task automatic wait_done(output int n);
    n = 0;
    while (n < 8) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
    end
  endtask

  task automatic run_cmd(input string tag, input logic [1:0] mode, aluop, shift,
                         input logic [2:0] rd, rn, rm, input logic [15:0] imm);
    int lat, n;
    @(negedge clk);
    drive(mode, aluop, shift, rd, rn, rm, imm);
    check({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    scramble();
    lat = model_exec(mode, aluop, shift, rd, rn, rm, imm);
    wait_done(n);
    check({tag, "_lat"}, n, lat);
    check({tag, "_ready_done"}, {31'd0, cmd_ready}, 32'd1);
    check_state(tag);
  endtask

  initial begin
    int n;
    model_reset();
    // 1: reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check_state("rst");

    // 2: MOVI + ADD with LSL1
    run_cmd("movi_r0", MMOVI, ADD, 2'b00, 3'd0, 3'd0, 3'd0, 16'd7);
    run_cmd("movi_r1", MMOVI, ADD, 2'b00, 3'd1, 3'd0, 3'd0, 16'd2);
    run_cmd("add_lsl", MALU, ADD, 2'b01, 3'd2, 3'd1, 3'd0, 16'd0);
    check("add_lsl_const", {16'd0, datapath_out}, 32'd16);

    // 3: CMP equal operands
    run_cmd("cmp_eq", MCMP, ADD, 2'b00, 3'd5, 3'd1, 3'd1, 16'd0);
    check("cmp_eq_z", {31'd0, Z_out}, 32'd1);

    // 4: signed overflow on ADD
    run_cmd("movi_r3", MMOVI, ADD, 2'b00, 3'd3, 3'd0, 3'd0, 16'h7FFF);
    run_cmd("movi_r4", MMOVI, ADD, 2'b00, 3'd4, 3'd0, 3'd0, 16'd1);
    run_cmd("add_ovf", MALU, ADD, 2'b00, 3'd5, 3'd3, 3'd4, 16'd0);
    check("add_ovf_const", {13'd0, datapath_out, Z_out, N_out, V_out}, {13'd0, 16'h8000, 3'b011});

    // 5: MOVR with ASR1 keeps flags, then MVN
    run_cmd("movr_asr", MMOVR, SUB, 2'b11, 3'd6, 3'd2, 3'd5, 16'd0);
    check("movr_asr_const", {13'd0, datapath_out, Z_out, N_out, V_out}, {13'd0, 16'hC000, 3'b011});
    run_cmd("mvn", MALU, MVN, 2'b00, 3'd7, 3'd0, 3'd6, 16'd0);
    check("mvn_const", {13'd0, datapath_out, Z_out, N_out, V_out}, {13'd0, 16'h3FFF, 3'b000});

    // Random commands, overlapping indices included
    for (int k = 0; k < 60; k++) begin
      run_cmd($sformatf("rnd%0d", k), 2'($urandom), 2'($urandom), 2'($urandom),
              3'($urandom), 3'($urandom), 3'($urandom), 16'($urandom));
    end

    // 6a: second command held while busy, accepted only at the done cycle
    @(negedge clk);
    drive(MALU, SUB, 2'b00, 3'd3, 3'd1, 3'd2, 16'd0);
    @(posedge clk); #1;
    drive(MMOVI, ADD, 2'b00, 3'd0, 3'd0, 3'd0, 16'h0055);
    void'(model_exec(MALU, SUB, 2'b00, 3'd3, 3'd1, 3'd2, 16'd0));
    n = 0;
    while (n < 8) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
      check($sformatf("busy_ready%0d", n), {31'd0, cmd_ready}, 32'd0);
    end
    check("busy_lat", n, 4);
    check_state("busy_first");
    @(posedge clk); #1;
    check("busy_second_acc", {30'd0, done, cmd_ready}, 32'd0);
    scramble();
    void'(model_exec(MMOVI, ADD, 2'b00, 3'd0, 3'd0, 3'd0, 16'h0055));
    @(posedge clk); #1;
    check("busy_second_done", {31'd0, done}, 32'd1);
    check_state("busy_second");

    // 6b: reset during EXEC aborts the operation
    @(negedge clk);
    drive(MALU, ADD, 2'b00, 3'd2, 3'd3, 3'd4, 16'd0);
    @(posedge clk); #1;
    scramble();
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_ready", {31'd0, cmd_ready}, 32'd1);
    check("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    check_state("abort");
    @(posedge clk); #1;
    check("abort_no_done", {31'd0, done}, 32'd0);
    run_cmd("post_rst", MMOVI, ADD, 2'b00, 3'd2, 3'd0, 3'd0, 16'hBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
